// File: rtl/alk_qshift_seq_if.sv
// Datapath-side bundle for the ALK A/Q shift sequencer: decoded ops, load data,
// sequence control and the A/Q/result outputs that feed the WBUS driver.
interface alk_qshift_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
);
  logic             op_shf_h;
  logic             op_rot_h;
  logic             op_qsi1_l;
  logic             op_asi1_l;
  logic             op_wbus30_h;
  logic             ld_a_h;
  logic             ld_q_h;
  logic [WIDTH-1:0] alu_h;
  logic [WIDTH-1:0] q_in_h;
  logic             asi_h;
  logic             start_h;
  logic [CNT_W-1:0] count_h;
  logic [WIDTH-1:0] a_h;
  logic [WIDTH-1:0] q_h;
  logic [WIDTH-1:0] result_h;
  logic             aso_h;
  logic             qso_h;
  logic             busy_h;
  logic             done_h;

  modport master (
    output op_shf_h, op_rot_h, op_qsi1_l, op_asi1_l, op_wbus30_h,
    output ld_a_h, ld_q_h, alu_h, q_in_h, asi_h, start_h, count_h,
    input  a_h, q_h, result_h, aso_h, qso_h, busy_h, done_h
  );

  modport slave (
    input  op_shf_h, op_rot_h, op_qsi1_l, op_asi1_l, op_wbus30_h,
    input  ld_a_h, ld_q_h, alu_h, q_in_h, asi_h, start_h, count_h,
    output a_h, q_h, result_h, aso_h, qso_h, busy_h, done_h
  );
endinterface

// File: rtl/alk_qshift_seq.sv
// Iterative A/Q shift sequencer for one ALK slice: latches the decoded shift op at
// start, then steps A and Q one bit per clock for the programmed count.
module alk_qshift_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic              clk_h,
  input  logic              reset_h,
  alk_qshift_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {M_NONE, M_ROT, M_SHF, M_QSH} mode_t;

  state_t           state;
  mode_t            mode;
  mode_t            mode_sel;
  logic             qsi1_force;
  logic             asi1_force;
  logic             wbus30;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] a_step;
  logic [WIDTH-1:0] q_step;
  logic             busy_r;
  logic             done_r;
  logic             q_msb;

  always_comb begin
    if (bus.op_rot_h)        mode_sel = M_ROT;
    else if (bus.op_shf_h)   mode_sel = M_SHF;
    else if (!bus.op_qsi1_l) mode_sel = M_QSH;
    else                     mode_sel = M_NONE;
  end

  // Forced-1 Q shift-in overrides A[0] as the Q MSB source in the double-width modes.
  assign q_msb = qsi1_force ? 1'b1 : a_r[0];

  // NOTE: every output of this block gets a default first, so no latch is inferred
  // on paths (M_NONE) that do not assign it.
  always_comb begin
    a_step = a_r;
    q_step = q_r;
    unique case (mode)
      M_ROT: begin
        a_step = {q_r[0], a_r[WIDTH-1:1]};
        q_step = {q_msb, q_r[WIDTH-1:1]};
      end
      M_SHF: begin
        a_step = {(asi1_force ? 1'b1 : bus.asi_h), a_r[WIDTH-1:1]};
        q_step = {q_msb, q_r[WIDTH-1:1]};
      end
      M_QSH:   q_step = {1'b1, q_r[WIDTH-1:1]};
      default: ;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples the
  // pre-edge values; reset is asynchronous so a mid-sequence abort is immediate.
  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      state      <= IDLE;
      mode       <= M_NONE;
      qsi1_force <= 1'b0;
      asi1_force <= 1'b0;
      wbus30     <= 1'b0;
      cnt        <= '0;
      a_r        <= '0;
      q_r        <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.ld_a_h) a_r <= bus.alu_h;
          if (bus.ld_q_h) q_r <= bus.q_in_h;
          // A start coinciding with a load is dropped; the load wins.
          if (bus.start_h && !bus.ld_a_h && !bus.ld_q_h) begin
            mode       <= mode_sel;
            qsi1_force <= ~bus.op_qsi1_l;
            asi1_force <= ~bus.op_asi1_l;
            wbus30     <= bus.op_wbus30_h;
            cnt        <= bus.count_h;
            if (bus.count_h != '0 && mode_sel != M_NONE) begin
              state  <= SHIFT;
              busy_r <= 1'b1;
            end else begin
              state  <= DONE;
              done_r <= 1'b1;
            end
          end
        end
        SHIFT: begin
          a_r <= a_step;
          q_r <= q_step;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_h      = a_r;
  assign bus.q_h      = q_r;
  assign bus.result_h = wbus30 ? q_r : a_r;
  assign bus.aso_h    = a_r[0];
  assign bus.qso_h    = q_r[0];
  assign bus.busy_h   = busy_r;
  assign bus.done_h   = done_r;

endmodule

// File: tb/tb_alk_qshift_seq.sv
// Directed bench for alk_qshift_seq: hand-computed A/Q results, busy/done timing,
// ignored inputs during a sequence and asynchronous abort.
module tb_alk_qshift_seq;

  logic clk_h = 1'b0;
  logic reset_h = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  alk_qshift_seq_if #(.WIDTH(8), .CNT_W(5)) bus ();

  alk_qshift_seq #(.WIDTH(8), .CNT_W(5)) dut (
    .clk_h   (clk_h),
    .reset_h (reset_h),
    .bus     (bus)
  );

  always #5 clk_h = ~clk_h;

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic idle_inputs();
    bus.op_shf_h    = 1'b0;
    bus.op_rot_h    = 1'b0;
    bus.op_qsi1_l   = 1'b1;
    bus.op_asi1_l   = 1'b1;
    bus.op_wbus30_h = 1'b0;
    bus.ld_a_h      = 1'b0;
    bus.ld_q_h      = 1'b0;
    bus.start_h     = 1'b0;
    bus.asi_h       = 1'b0;
    bus.count_h     = '0;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] q);
    bus.ld_a_h = 1'b1;
    bus.ld_q_h = 1'b1;
    bus.alu_h  = a;
    bus.q_in_h = q;
    tick();
    bus.ld_a_h = 1'b0;
    bus.ld_q_h = 1'b0;
  endtask

  // Ops are dropped right after the start edge so only the latched copy matters.
  task automatic do_start(input logic rot, input logic shf, input logic qsi1_l,
                          input logic asi1_l, input logic wb30, input logic [4:0] cnt);
    bus.op_rot_h    = rot;
    bus.op_shf_h    = shf;
    bus.op_qsi1_l   = qsi1_l;
    bus.op_asi1_l   = asi1_l;
    bus.op_wbus30_h = wb30;
    bus.count_h     = cnt;
    bus.start_h     = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic wait_done(output int busy_n, output bit ok);
    busy_n = 0;
    ok     = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done_h) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy_h) busy_n++;
      tick();
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({bus.a_h, bus.q_h, bus.result_h, bus.busy_h, bus.done_h} !== 27'd0) begin
      $display("FAIL reset_state got a=%h q=%h r=%h busy=%b done=%b want all 0",
               bus.a_h, bus.q_h, bus.result_h, bus.busy_h, bus.done_h);
      n_err++;
    end
  endtask

  task automatic test_rot_one();
    int busy_n;
    bit ok;
    load(8'h81, 8'h01);
    n_vec++;
    if ({bus.aso_h, bus.qso_h} !== 2'b11) begin
      $display("FAIL serial_out got aso=%b qso=%b want 1 1", bus.aso_h, bus.qso_h); n_err++;
    end
    do_start(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1);
    wait_done(busy_n, ok);
    n_vec++;
    if (!ok || busy_n != 1 || bus.a_h !== 8'hC0 || bus.q_h !== 8'h80) begin
      $display("FAIL rot1 got ok=%b busy=%0d a=%h q=%h want 1 1 c0 80", ok, busy_n, bus.a_h, bus.q_h);
      n_err++;
    end
    tick();
    n_vec++;
    if (bus.done_h !== 1'b0) begin
      $display("FAIL rot1_done_width got done=%b want 0", bus.done_h); n_err++;
    end
  endtask

  task automatic test_shf_forced();
    int busy_n;
    bit ok;
    load(8'h00, 8'hFF);
    do_start(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4);
    wait_done(busy_n, ok);
    n_vec++;
    if (!ok || busy_n != 4 || bus.a_h !== 8'hF0 || bus.q_h !== 8'h0F) begin
      $display("FAIL shf4 got ok=%b busy=%0d a=%h q=%h want 1 4 f0 0f", ok, busy_n, bus.a_h, bus.q_h);
      n_err++;
    end
    tick();
  endtask

  task automatic test_qsh_wbus30();
    int busy_n;
    bit ok;
    load(8'h5A, 8'h00);
    do_start(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3);
    wait_done(busy_n, ok);
    n_vec++;
    if (!ok || busy_n != 3 || bus.a_h !== 8'h5A || bus.q_h !== 8'hE0 || bus.result_h !== 8'hE0) begin
      $display("FAIL qsh3 got ok=%b busy=%0d a=%h q=%h r=%h want 1 3 5a e0 e0",
               ok, busy_n, bus.a_h, bus.q_h, bus.result_h);
      n_err++;
    end
    tick();
  endtask

  task automatic test_zero_and_none();
    // count=0 with a valid op, then a nonzero count with no op: both skip SHIFT.
    do_start(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
    n_vec++;
    if (bus.done_h !== 1'b1 || bus.busy_h !== 1'b0 || bus.a_h !== 8'h5A || bus.q_h !== 8'hE0
        || bus.result_h !== 8'h5A) begin
      $display("FAIL count0 got done=%b busy=%b a=%h q=%h r=%h want 1 0 5a e0 5a",
               bus.done_h, bus.busy_h, bus.a_h, bus.q_h, bus.result_h);
      n_err++;
    end
    tick();
    do_start(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5);
    n_vec++;
    if (bus.done_h !== 1'b1 || bus.busy_h !== 1'b0 || bus.q_h !== 8'hE0) begin
      $display("FAIL mode_none got done=%b busy=%b q=%h want 1 0 e0", bus.done_h, bus.busy_h, bus.q_h);
      n_err++;
    end
    tick();
  endtask

  task automatic test_ld_with_start();
    bus.ld_a_h  = 1'b1;
    bus.alu_h   = 8'h33;
    bus.op_rot_h = 1'b1;
    bus.count_h = 5'd3;
    bus.start_h = 1'b1;
    tick();
    idle_inputs();
    n_vec++;
    if (bus.a_h !== 8'h33 || bus.busy_h !== 1'b0 || bus.done_h !== 1'b0) begin
      $display("FAIL ld_start got a=%h busy=%b done=%b want 33 0 0", bus.a_h, bus.busy_h, bus.done_h);
      n_err++;
    end
  endtask

  task automatic test_priority_and_qforce();
    int busy_n;
    bit ok;
    // ROT beats SHF: rotate puts Q[0]=1 into A MSB, SHF with asi_h=0 would not.
    load(8'h01, 8'h01);
    do_start(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1);
    wait_done(busy_n, ok);
    n_vec++;
    if (!ok || bus.a_h !== 8'h80 || bus.q_h !== 8'h80) begin
      $display("FAIL rot_prio got ok=%b a=%h q=%h want 1 80 80", ok, bus.a_h, bus.q_h); n_err++;
    end
    tick();
    // ROT with the Q-force-1 op: Q MSB fills with 1 instead of A[0]=0.
    load(8'h00, 8'h00);
    do_start(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2);
    wait_done(busy_n, ok);
    n_vec++;
    if (!ok || busy_n != 2 || bus.a_h !== 8'h00 || bus.q_h !== 8'hC0) begin
      $display("FAIL rot_qforce got ok=%b busy=%0d a=%h q=%h want 1 2 00 c0", ok, busy_n, bus.a_h, bus.q_h);
      n_err++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int busy_n;
    int busy_pre;
    bit ok;
    load(8'h12, 8'h34);
    do_start(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd20);
    busy_pre = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.busy_h) busy_pre++;
      if (i == 4) begin
        bus.start_h = 1'b1;
        bus.ld_a_h  = 1'b1;
        bus.alu_h   = 8'hFF;
        bus.op_shf_h = 1'b1;
        bus.count_h = 5'd2;
      end
      tick();
    end
    idle_inputs();
    wait_done(busy_n, ok);
    // 20-step rotate of {A,Q}=0x1234 is a 4-bit rotate: 0x4123.
    n_vec++;
    if (!ok || busy_pre + busy_n != 20 || bus.a_h !== 8'h41 || bus.q_h !== 8'h23) begin
      $display("FAIL rot20 got ok=%b busy=%0d a=%h q=%h want 1 20 41 23",
               ok, busy_pre + busy_n, bus.a_h, bus.q_h);
      n_err++;
    end
    tick();
  endtask

  task automatic test_abort();
    bit saw_done;
    load(8'h12, 8'h34);
    do_start(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd20);
    for (int i = 0; i < 9; i++) tick();
    reset_h = 1'b1;
    #1;
    n_vec++;
    if ({bus.a_h, bus.q_h, bus.result_h, bus.aso_h, bus.qso_h, bus.busy_h, bus.done_h} !== 29'd0) begin
      $display("FAIL abort got a=%h q=%h r=%h busy=%b done=%b want all 0",
               bus.a_h, bus.q_h, bus.result_h, bus.busy_h, bus.done_h);
      n_err++;
    end
    tick();
    reset_h = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done_h || bus.busy_h) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done !== 1'b0) begin
      $display("FAIL abort_quiet got busy/done activity=%b want 0", saw_done); n_err++;
    end
  endtask

  task automatic test_shf_serial();
    load(8'h00, 8'h00);
    do_start(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    bus.asi_h = 1'b1;
    tick();
    bus.asi_h = 1'b0;
    tick();
    bus.asi_h = 1'b1;
    tick();
    bus.asi_h = 1'b0;
    n_vec++;
    if (bus.done_h !== 1'b1 || bus.a_h !== 8'hA0 || bus.q_h !== 8'h00 || bus.result_h !== 8'hA0) begin
      $display("FAIL shf_serial got done=%b a=%h q=%h r=%h want 1 a0 00 a0",
               bus.done_h, bus.a_h, bus.q_h, bus.result_h);
      n_err++;
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    bus.alu_h  = '0;
    bus.q_in_h = '0;
    #3;
    test_reset();
    tick();
    reset_h = 1'b0;
    tick();
    test_rot_one();
    test_shf_forced();
    test_qsh_wbus30();
    test_zero_and_none();
    test_ld_with_start();
    test_priority_and_qforce();
    test_back_to_back();
    test_abort();
    test_shf_serial();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
